// File: rtl/line_follow_pi_cntrl.sv
// Line-follower IR sequencer with PI steering loop and ramped forward speed.
// Optional IR_PWM_EN: active IR emitter bit gated by an 8-bit free-running PWM.
module line_follow_pi_cntrl #(
    parameter int              NUM_PAIRS  = 3,
    parameter int              RES_W      = 12,
    parameter int              SETTLE_CYC = 4096,
    parameter int              GAP_CYC    = 32,
    parameter logic [15:0]     KP         = 16'h3680,
    parameter logic [15:0]     KI         = 16'h0500,
    parameter int              INT_DEC    = 4,
    parameter logic [RES_W-1:0] FWD_MAX   = 12'h700
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 strt_cnv,
    output logic [2:0]           chnnl,
    input  logic                 cnv_cmplt,
    input  logic [RES_W-1:0]     A2D_res,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [7:0]           LEDs,
    output logic [RES_W-2:0]     lft,
    output logic [RES_W-2:0]     rht,
    output logic                 frm_done
);

    localparam int AW = RES_W + NUM_PAIRS + 1;
    localparam int PW = RES_W + 17;
    localparam int CMAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int CW = $clog2(CMAX + 1);
    localparam int FW = $clog2(INT_DEC + 1);
    localparam logic signed [PW-1:0] P_HI = {{(PW-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic signed [PW-1:0] P_LO = ~P_HI;

    typedef enum logic [3:0] {
        IDLE, SETTLE, CNV_R, GAP, CNV_L, NEXT,
        ERR, INTG, PMUL, IMUL, MOT_R, MOT_L
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [1:0]                r_p;
    logic [FW-1:0]             r_fc;
    logic                      r_ph;
    logic                      r_strt;
    logic                      r_frm;
    logic [2:0]                r_chnnl;
    logic signed [AW-1:0]      r_acc;
    logic signed [RES_W-1:0]   r_err;
    logic signed [RES_W-1:0]   r_int;
    logic signed [RES_W-1:0]   r_pc;
    logic signed [RES_W-1:0]   r_ic;
    logic signed [RES_W-1:0]   r_fwd;
    logic signed [RES_W-1:0]   r_lft;
    logic signed [RES_W-1:0]   r_rht;
    logic signed [PW-1:0]      r_prod;

    logic signed [AW-1:0]      w_sh;
    logic signed [PW-1:0]      w_acc_x;
    logic signed [PW-1:0]      w_err_x;
    logic signed [PW-1:0]      w_int_x;
    logic signed [PW-1:0]      w_fwd_x;
    logic signed [PW-1:0]      w_pc_x;
    logic signed [PW-1:0]      w_ic_x;
    logic signed [PW-1:0]      w_kp_x;
    logic signed [PW-1:0]      w_ki_x;
    logic [NUM_PAIRS-1:0]      w_ir;
    logic                      w_win;
    logic                      w_unused;

    function automatic logic signed [RES_W-1:0] sat(input logic signed [PW-1:0] v);
        if (v > P_HI)
            sat = {1'b0, {(RES_W-1){1'b1}}};
        else if (v < P_LO)
            sat = {1'b1, {(RES_W-1){1'b0}}};
        else
            sat = v[RES_W-1:0];
    endfunction

    function automatic logic [2:0] rch(input logic [1:0] p);
        case (p)
            2'd0:    rch = 3'd1;
            2'd1:    rch = 3'd4;
            2'd2:    rch = 3'd3;
            default: rch = 3'd5;
        endcase
    endfunction

    function automatic logic [2:0] lch(input logic [1:0] p);
        case (p)
            2'd0:    lch = 3'd0;
            2'd1:    lch = 3'd2;
            2'd2:    lch = 3'd7;
            default: lch = 3'd6;
        endcase
    endfunction

    // A2D results are unsigned magnitudes, weighted by 2^pair
    assign w_sh    = $signed({{(AW-RES_W){1'b0}}, A2D_res} << r_p);
    assign w_acc_x = {{(PW-AW){r_acc[AW-1]}}, r_acc};
    assign w_err_x = {{(PW-RES_W){r_err[RES_W-1]}}, r_err};
    assign w_int_x = {{(PW-RES_W){r_int[RES_W-1]}}, r_int};
    assign w_fwd_x = {{(PW-RES_W){r_fwd[RES_W-1]}}, r_fwd};
    assign w_pc_x  = {{(PW-RES_W){r_pc[RES_W-1]}}, r_pc};
    assign w_ic_x  = {{(PW-RES_W){r_ic[RES_W-1]}}, r_ic};
    assign w_kp_x  = {{(PW-16){1'b0}}, KP};
    assign w_ki_x  = {{(PW-16){1'b0}}, KI};

    assign w_win = (r_state == SETTLE) || (r_state == CNV_R) ||
                   (r_state == GAP) || (r_state == CNV_L);
    assign w_ir  = w_win ? (NUM_PAIRS'(1) << r_p) : '0;

`ifdef IR_PWM_EN
    localparam logic [7:0] IR_DUTY = 8'h8C;
    logic [7:0] r_pwm;

    always_ff @(posedge clk) begin
        if (rst)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 8'd1;
    end

    assign IR_en = (r_pwm < IR_DUTY) ? w_ir : '0;
`else
    assign IR_en = w_ir;
`endif

    assign strt_cnv = r_strt;
    assign chnnl    = r_chnnl;
    assign frm_done = r_frm;
    assign LEDs     = r_err[RES_W-1:RES_W-8];
    assign lft      = r_lft[RES_W-1:1];
    assign rht      = r_rht[RES_W-1:1];
    assign w_unused = ^{r_lft[0], r_rht[0]};

    always_ff @(posedge clk) begin
        if (rst || !go) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_p     <= '0;
            r_fc    <= '0;
            r_ph    <= 1'b0;
            r_strt  <= 1'b0;
            r_frm   <= 1'b0;
            r_chnnl <= '0;
            r_acc   <= '0;
            r_err   <= '0;
            r_int   <= '0;
            r_pc    <= '0;
            r_ic    <= '0;
            r_fwd   <= '0;
            r_lft   <= '0;
            r_rht   <= '0;
            r_prod  <= '0;
        end else begin
            r_strt <= 1'b0;
            r_frm  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_acc   <= '0;
                    r_p     <= '0;
                    r_cnt   <= '0;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_strt  <= 1'b1;
                        r_chnnl <= rch(r_p);
                        r_state <= CNV_R;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                CNV_R: begin
                    if (cnv_cmplt) begin
                        r_acc   <= r_acc + w_sh;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_cnt == CW'(GAP_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_strt  <= 1'b1;
                        r_chnnl <= lch(r_p);
                        r_state <= CNV_L;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                CNV_L: begin
                    if (cnv_cmplt) begin
                        r_acc   <= r_acc - w_sh;
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_p == 2'(NUM_PAIRS - 1)) begin
                        r_state <= ERR;
                    end else begin
                        r_p     <= r_p + 2'd1;
                        r_state <= SETTLE;
                    end
                end
                ERR: begin
                    r_err <= sat(w_acc_x);
                    if (r_fc == FW'(INT_DEC - 1))
                        r_fc <= '0;
                    else
                        r_fc <= r_fc + FW'(1);
                    r_state <= INTG;
                end
                INTG: begin
                    if (r_fc == '0) begin
                        r_int <= sat(w_int_x + w_err_x);
                        if ($unsigned(r_fwd) < FWD_MAX)
                            r_fwd <= r_fwd + {{(RES_W-1){1'b0}}, 1'b1};
                    end
                    r_ph    <= 1'b0;
                    r_state <= PMUL;
                end
                PMUL: begin
                    if (!r_ph) begin
                        r_prod <= w_err_x * w_kp_x;
                        r_ph   <= 1'b1;
                    end else begin
                        r_pc    <= sat(r_prod >>> 12);
                        r_ph    <= 1'b0;
                        r_state <= IMUL;
                    end
                end
                IMUL: begin
                    if (!r_ph) begin
                        r_prod <= w_int_x * w_ki_x;
                        r_ph   <= 1'b1;
                    end else begin
                        r_ic    <= sat(r_prod >>> 12);
                        r_ph    <= 1'b0;
                        r_state <= MOT_R;
                    end
                end
                MOT_R: begin
                    r_rht   <= sat(w_fwd_x - w_pc_x - w_ic_x);
                    r_state <= MOT_L;
                end
                MOT_L: begin
                    r_lft   <= sat(w_fwd_x + w_pc_x + w_ic_x);
                    r_frm   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_follow_pi_cntrl.sv
// Randomized frame-level check of line_follow_pi_cntrl against a PI model.
module tb_line_follow_pi_cntrl;

    localparam int NP = 3;
    localparam int ST = 16;
    localparam int GP = 8;
    localparam int ID = 4;
    localparam int FM = 16;
    localparam longint KPV = 'h3680;
    localparam longint KIV = 'h0500;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic [2:0]  IR_en;
    logic [7:0]  LEDs;
    logic [10:0] lft;
    logic [10:0] rht;
    logic        frm_done;

    line_follow_pi_cntrl #(
        .NUM_PAIRS(NP), .RES_W(12), .SETTLE_CYC(ST), .GAP_CYC(GP),
        .KP(16'h3680), .KI(16'h0500), .INT_DEC(ID), .FWD_MAX(12'h010)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .IR_en(IR_en),
        .LEDs(LEDs), .lft(lft), .rht(rht), .frm_done(frm_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int chv[8];
    bit auto_en = 1'b0;
    int m_int, m_fwd, m_fc;
    int rmap[4] = '{1, 4, 3, 5};
    int lmap[4] = '{0, 2, 7, 6};
    int a_lft, a_rht, a_led;

    function automatic int sat(longint v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return int'(v);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic reset_model();
        m_int = 0;
        m_fwd = 0;
        m_fc  = 0;
    endtask

    // One frame of the controller, from the channel table to motor commands
    task automatic model_frame(output int el, output int er, output int eled);
        longint acc;
        int err, pc, ic;
        acc = 0;
        for (int p = 0; p < NP; p++)
            acc += longint'(chv[rmap[p]] - chv[lmap[p]]) * (longint'(1) << p);
        err = sat(acc);
        m_fc = (m_fc + 1) % ID;
        if (m_fc == 0) begin
            m_int = sat(longint'(m_int) + err);
            if (m_fwd < FM) m_fwd++;
        end
        pc = sat((longint'(err) * KPV) >>> 12);
        ic = sat((longint'(m_int) * KIV) >>> 12);
        el = sat(longint'(m_fwd) + pc + ic) >>> 1;
        er = sat(longint'(m_fwd) - pc - ic) >>> 1;
        eled = (err >>> 4) & 255;
    endtask

    task automatic do_frame(string tag);
        int n, el, er, eled;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frm_done && n < 1000);
        if (!frm_done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            model_frame(el, er, eled);
            a_lft = int'($signed(lft));
            a_rht = int'($signed(rht));
            a_led = int'(LEDs);
            chk({tag, "_lft"}, a_lft, el);
            chk({tag, "_rht"}, a_rht, er);
            chk({tag, "_leds"}, a_led, eled);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_strt"}, int'(strt_cnv), 0);
        chk({tag, "_chnnl"}, int'(chnnl), 0);
        chk({tag, "_ir"}, int'(IR_en), 0);
        chk({tag, "_leds"}, int'(LEDs), 0);
        chk({tag, "_lft"}, int'(lft), 0);
        chk({tag, "_rht"}, int'(rht), 0);
        chk({tag, "_frm"}, int'(frm_done), 0);
    endtask

    task automatic pulse_cmplt(int v);
        repeat (2) @(negedge clk);
        A2D_res = 12'(v);
        cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
    endtask

    task automatic wait_strt(output int n);
        n = 0;
        while (!strt_cnv && n < 200 + ST) begin
            @(negedge clk);
            n++;
        end
    endtask

    // go rises, first pair-0 right conversion timed and served by hand
    task automatic first_conv(string tag);
        int n;
        auto_en = 1'b0;
        go = 1'b1;
        wait_strt(n);
        chk({tag, "_settle_lat"}, n, ST + 1);
        chk({tag, "_ch_r0"}, int'(chnnl), 1);
        chk({tag, "_ir_r0"}, int'(IR_en), 1);
        pulse_cmplt(chv[1]);
    endtask

    task automatic do_rst();
        auto_en = 1'b0;
        go = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    initial begin : responder
        int ch, pp;
        cnv_cmplt = 1'b0;
        A2D_res = '0;
        forever begin
            @(negedge clk);
            if (auto_en && strt_cnv && !rst) begin
                ch = int'(chnnl);
                pp = 0;
                for (int p = 0; p < NP; p++)
                    if (rmap[p] == ch || lmap[p] == ch) pp = p;
                chk("ir_onehot", int'(IR_en), 1 << pp);
                repeat ($urandom_range(1, 4)) @(negedge clk);
                A2D_res = 12'(chv[ch]);
                cnv_cmplt = 1'b1;
                @(negedge clk);
                cnv_cmplt = 1'b0;
            end
        end
    end

    initial begin : main
        int n;
        rst = 1'b1;
        go = 1'b0;
        foreach (chv[i]) chv[i] = 'h100;
        reset_model();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // balanced pairs, plus entry and gap timing
        first_conv("t4");
        wait_strt(n);
        chk("t4_gap_lat", n, GP);
        chk("t4_ch_l0", int'(chnnl), 0);
        pulse_cmplt(chv[0]);
        auto_en = 1'b1;
        do_frame("t1_f1");
        chk("t1_lit_lft", a_lft, 0);
        chk("t1_lit_rht", a_rht, 0);
        chk("t1_lit_leds", a_led, 0);
        for (int f = 0; f < 5; f++) do_frame("t1");

        // single pair-0 right excitation
        do_rst();
        foreach (chv[i]) chv[i] = 0;
        chv[1] = 'h200;
        go = 1'b1;
        auto_en = 1'b1;
        do_frame("t2");
        chk("t2_lit_lft", a_lft, 872);
        chk("t2_lit_rht", a_rht, -872);
        chk("t2_lit_leds", a_led, 'h20);

        // full-scale right side saturates Error
        do_rst();
        foreach (chv[i]) chv[i] = 0;
        chv[1] = 'hFFF; chv[4] = 'hFFF; chv[3] = 'hFFF;
        go = 1'b1;
        auto_en = 1'b1;
        do_frame("t3");
        chk("t3_lit_leds", a_led, 'h7F);
        chk("t3_lit_lft", a_lft, 1023);
        chk("t3_lit_rht", a_rht, -1024);

        // drop go in CNV_R, late cnv_cmplt must be ignored
        auto_en = 1'b0;
        wait_strt(n);
        chk("t5_in_cnv_r", int'(strt_cnv), 1);
        go = 1'b0;
        @(negedge clk);
        A2D_res = 12'hFFF;
        cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        @(negedge clk);
        chk("t5_lft", int'(lft), 0);
        chk("t5_rht", int'(rht), 0);
        chk("t5_ir", int'(IR_en), 0);
        chk("t5_leds", int'(LEDs), 0);
        reset_model();
        foreach (chv[i]) chv[i] = 0;
        chv[1] = 'h40;
        first_conv("t5");
        auto_en = 1'b1;
        do_frame("t5");
        chk("t5_lit_lft", a_lft, 109);
        chk("t5_lit_rht", a_rht, -109);

        // random frames with occasional go drops
        for (int f = 0; f < 40; f++) begin
            foreach (chv[i]) chv[i] = int'($urandom_range(0, 4095) >> $urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) begin
                auto_en = 1'b0;
                go = 1'b0;
                repeat (2) @(negedge clk);
                reset_model();
                go = 1'b1;
                auto_en = 1'b1;
            end
            do_frame("rnd");
        end

        // Fwd ramp ceiling with zero error
        do_rst();
        foreach (chv[i]) chv[i] = 'h123;
        go = 1'b1;
        auto_en = 1'b1;
        for (int f = 0; f < 4 * (FM + 3); f++) do_frame("t6");
        chk("t6_lit_lft", a_lft, FM / 2);
        chk("t6_lit_rht", a_rht, FM / 2);
        repeat (30) @(negedge clk);
        auto_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t6_rst");
        rst = 1'b0;
        go = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
